// File: rtl/components_pkg.sv
// Shared types and constants for small conditioning/control blocks.
package components_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Plain two-flop synchronizer for bringing a single asynchronous bit into clk.
module sync_2ff
    import components_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces one asynchronous input; emits clean level plus edge pulses.
//   state     | meaning
//   IDLE_LOW  | dout=0 settled
//   WAIT_HIGH | qualifying a 0->1 change
//   IDLE_HIGH | dout=1 settled
//   WAIT_LOW  | qualifying a 1->0 change
module debounce_sync
    import components_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    debounce_state_t  r_state;
    debounce_state_t  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             w_dout_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_busy_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                w_dout_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_dout_nxt  = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                w_dout_nxt = 1'b1;
                if (!w_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_dout_nxt  = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_dout_nxt  = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed timing scenarios plus random din against a window-based model.
module tb_debounce_sync;

    localparam int NS [2] = '{4, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout4, rise4, fall4, busy4;
    logic dout2, rise2, fall2, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    debounce_sync #(.STABLE_CYCLES(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout4),
        .rise (rise4),
        .fall (fall4),
        .busy (busy4)
    );

    debounce_sync #(.STABLE_CYCLES(2)) u_dut2 (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout2),
        .rise (rise2),
        .fall (fall2),
        .busy (busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dut_o(input int i);
        return (i == 0) ? {dout4, rise4, fall4, busy4} : {dout2, rise2, fall2, busy2};
    endfunction

    // Model: a level change is accepted when the last N synchronized samples all
    // disagree with the current output; s is din delayed by two clock samples.
    bit [63:0] m_hist [2] = '{64'd0, 64'd0};
    logic      m_dout [2] = '{1'b0, 1'b0};
    logic      m_rise [2] = '{1'b0, 1'b0};
    logic      m_fall [2] = '{1'b0, 1'b0};
    logic      m_busy [2] = '{1'b0, 1'b0};
    logic      m_pipe0 = 1'b0;
    logic      m_pipe1 = 1'b0;
    bit        m_opp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_hist[i] = '0;
                m_dout[i] = 1'b0;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                m_busy[i] = 1'b0;
            end
            m_pipe0 = 1'b0;
            m_pipe1 = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hist[i] = {m_hist[i][62:0], m_pipe1};
                m_opp = 1'b1;
                for (int j = 0; j < NS[i]; j++) begin
                    if (m_hist[i][j] == m_dout[i]) m_opp = 1'b0;
                end
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (m_opp) begin
                    m_dout[i] = ~m_dout[i];
                    if (m_dout[i]) m_rise[i] = 1'b1;
                    else           m_fall[i] = 1'b1;
                end
                m_busy[i] = (m_hist[i][0] != m_dout[i]);
            end
            m_pipe1 = m_pipe0;
            m_pipe0 = din;
        end
    end

    logic [3:0] cmp_o;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cmp_o = dut_o(i);
            chk($sformatf("model_dout[N=%0d]", NS[i]), int'(cmp_o[3]), int'(m_dout[i]));
            chk($sformatf("model_rise[N=%0d]", NS[i]), int'(cmp_o[2]), int'(m_rise[i]));
            chk($sformatf("model_fall[N=%0d]", NS[i]), int'(cmp_o[1]), int'(m_fall[i]));
            chk($sformatf("model_busy[N=%0d]", NS[i]), int'(cmp_o[0]), int'(m_busy[i]));
            chk($sformatf("rise_fall_excl[N=%0d]", NS[i]), int'(cmp_o[2] & cmp_o[1]), 0);
        end
    end

    int first_busy [2];
    int first_rise [2];
    int first_fall [2];
    int n_rise     [2];
    int n_fall     [2];

    // Called at a negedge; drives pat[e-1] ahead of edge e, then hold; records edge indices.
    task automatic watch(input logic [31:0] pat, input int plen, input logic hold, input int cycles);
        logic [3:0] o;
        for (int i = 0; i < 2; i++) begin
            first_busy[i] = -1;
            first_rise[i] = -1;
            first_fall[i] = -1;
            n_rise[i]     = 0;
            n_fall[i]     = 0;
        end
        for (int e = 1; e <= cycles; e++) begin
            din = (e <= plen) ? pat[e-1] : hold;
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                o = dut_o(i);
                if (o[0] && first_busy[i] < 0) first_busy[i] = e;
                if (o[2]) begin
                    n_rise[i]++;
                    if (first_rise[i] < 0) first_rise[i] = e;
                end
                if (o[1]) begin
                    n_fall[i]++;
                    if (first_fall[i] < 0) first_fall[i] = e;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s[N=%0d]", tag, NS[i]), int'(dut_o(i)), 0);
        end
    endtask

    int hold_left;

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        watch(32'd0, 0, 1'b0, 6);
        chk("idle_no_rise[N=4]", n_rise[0], 0);
        chk("idle_no_busy[N=4]", first_busy[0], -1);

        // Clean rise
        watch(32'd0, 0, 1'b1, 12);
        chk("rise_busy_edge[N=4]", first_busy[0], 3);
        chk("rise_edge[N=4]", first_rise[0], 6);
        chk("rise_edge[N=2]", first_rise[1], 4);
        chk("rise_count[N=4]", n_rise[0], 1);
        chk("rise_count[N=2]", n_rise[1], 1);
        chk("rise_no_fall[N=4]", n_fall[0], 0);
        chk("rise_dout[N=4]", int'(dout4), 1);

        // Clean fall
        watch(32'd0, 0, 1'b0, 12);
        chk("fall_edge[N=4]", first_fall[0], 6);
        chk("fall_edge[N=2]", first_fall[1], 4);
        chk("fall_count[N=4]", n_fall[0], 1);
        chk("fall_no_rise[N=4]", n_rise[0], 0);
        chk("fall_dout[N=4]", int'(dout4), 0);

        // Two-cycle glitch: rejected at N=4, accepted at N=2
        watch(32'b11, 2, 1'b0, 15);
        chk("glitch_busy_edge[N=4]", first_busy[0], 3);
        chk("glitch_no_rise[N=4]", n_rise[0], 0);
        chk("glitch_dout[N=4]", int'(dout4), 0);
        chk("glitch_rise[N=2]", n_rise[1], 1);
        chk("glitch_fall[N=2]", n_fall[1], 1);

        // One-cycle pulse at the minimum stability setting
        watch(32'b1, 1, 1'b0, 10);
        chk("pulse1_no_rise[N=2]", n_rise[1], 0);
        chk("pulse1_dout[N=2]", int'(dout2), 0);

        // Three-cycle pulse
        watch(32'b111, 3, 1'b0, 12);
        chk("pulse3_rise_edge[N=2]", first_rise[1], 4);
        chk("pulse3_fall_edge[N=2]", first_fall[1], 7);
        chk("pulse3_rise_count[N=2]", n_rise[1], 1);
        chk("pulse3_fall_count[N=2]", n_fall[1], 1);
        chk("pulse3_no_rise[N=4]", n_rise[0], 0);

        // Bounce 1,0,1,0,1 then hold high
        watch(32'b10101, 5, 1'b1, 16);
        chk("bounce_rise_edge[N=4]", first_rise[0], 10);
        chk("bounce_rise_edge[N=2]", first_rise[1], 8);
        chk("bounce_rise_count[N=4]", n_rise[0], 1);
        chk("bounce_rise_count[N=2]", n_rise[1], 1);
        chk("bounce_no_fall[N=4]", n_fall[0], 0);
        chk("bounce_dout[N=4]", int'(dout4), 1);

        watch(32'd0, 0, 1'b0, 10);

        // Reset in the middle of qualification
        din = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midqual_busy[N=4]", int'(busy4), 1);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("midqual_reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        watch(32'd0, 0, 1'b1, 12);
        chk("post_reset_rise_edge[N=4]", first_rise[0], 6);
        chk("post_reset_rise_edge[N=2]", first_rise[1], 4);
        chk("post_reset_rise_count[N=4]", n_rise[0], 1);

        // Random din with varying hold lengths and occasional async reset
        hold_left = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (hold_left == 0) begin
                din       = 1'($urandom_range(1, 0));
                hold_left = int'($urandom_range(7, 1));
            end
            hold_left--;
            if ($urandom_range(99, 0) == 0) begin
                @(posedge clk);
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
